cci_mpf_quiesce_ctrl: RTL and testbench
=======================================

// Module: cci_mpf_quiesce_ctrl
// PURPOSE
//  Sequences an MPF instance into and out of a quiesced state for AFU context switch.
//  On request it blocks new AFU traffic and waits for both channels to drain.
//  It can then inject a WrFence and wait for the fence response before reporting quiesced.
//  Sits beside cci_mpf: consumes its c0NotEmpty/c1NotEmpty and gates the AFU TX path.
// PARAMETERS
//  TX_SKEW_CYCLES  8      cycles between asserting afu_tx_block and sampling not-empty.
//                         Covers the CCI-P almost-full skid plus the 1-cycle NotEmpty register lag.
//  ISSUE_WRFENCE   1      1: issue WrFence after drain; 0: skip the FENCE states.
//  FENCE_MDATA     'h3FF  16-bit mdata tag placed on the injected fence.
//                         Bits [15:12] are 0, reserved for the AFU mux.
//  TIMEOUT_CYCLES  65536  DRAIN/FENCE_WAIT watchdog limit; must be >= 2.
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high reset
//  quiesce_req      in   1   level; high = quiesce wanted, low = resume
//  quiesce_done     out  1   high only in state QUIESCED
//  quiesce_timeout  out  1   sticky watchdog flag
//  c0_not_empty     in   1   MPF c0NotEmpty (reads outstanding)
//  c1_not_empty     in   1   MPF c1NotEmpty (writes outstanding)
//  afu_tx_block     out  1   forces AFU almost-full and masks AFU TX valid
//  c1_tx_almost_full in  1   FIU-side c1 almost-full, gates fence issue
//  fence_valid      out  1   one-cycle WrFence injection strobe on c1
//  fence_mdata      out  16  constant FENCE_MDATA
//  fence_rsp_valid  in   1   c1 RX fence response valid
//  fence_rsp_mdata  in   16  mdata of that response
//  state_dbg        out  3   encoded FSM state, for CSR readout
// BEHAVIOUR
//  Reset values: all 1-bit outputs 0; state_dbg = IDLE (0); counters 0.
//  All outputs are registered.
//  FSM encodings: IDLE=0, BLOCK=1, DRAIN=2, FENCE=3, FENCE_WAIT=4, QUIESCED=5.
//  IDLE
//   - quiesce_req=1 -> BLOCK.
//   - In the same edge: afu_tx_block<=1, quiesce_timeout<=0, skew counter<=0.
//  BLOCK
//   - Skew counter increments each cycle.
//   - At TX_SKEW_CYCLES-1 -> DRAIN, watchdog<=0.
//   - quiesce_req=0 -> IDLE with afu_tx_block<=0 (abort).
//  DRAIN
//   - !c0_not_empty && !c1_not_empty in the same cycle -> FENCE if ISSUE_WRFENCE, else QUIESCED.
//   - quiesce_req=0 -> IDLE (abort); abort wins over drain-complete in the same cycle.
//  FENCE
//   - fence_valid=1 for exactly one cycle, the first cycle c1_tx_almost_full=0.
//   - Same edge -> FENCE_WAIT, watchdog<=0.
//   - Not abortable.
//  FENCE_WAIT
//   - fence_rsp_valid && fence_rsp_mdata==FENCE_MDATA -> QUIESCED if quiesce_req, else IDLE.
//   - Non-matching responses are ignored.
//   - quiesce_req drop is deferred until the response arrives; an outstanding fence is never abandoned.
//  QUIESCED
//   - quiesce_done=1 and afu_tx_block=1.
//   - quiesce_req=0 -> IDLE; next cycle quiesce_done=0, afu_tx_block=0.
//  Watchdog
//   - Runs in DRAIN/FENCE_WAIT and saturates; it does not wrap.
//   - On reaching TIMEOUT_CYCLES-1, quiesce_timeout<=1.
//   - The flag stays set until reset or the next IDLE->BLOCK.
//   - The FSM keeps waiting; the flag is report-only.
//  Latency
//   - Minimum req->done with fence: 1 + TX_SKEW_CYCLES + 1 + 1 + fence RTT cycles.
//   - Without fence: 2 + TX_SKEW_CYCLES.
//  reset mid-sequence: immediate return to IDLE, block released.
//   - Any fence already issued is the caller's concern; its response is ignored in IDLE.
//  Counter widths: $clog2(limit)+1 bits each.
// TESTING
//  1. Idle MPF, ISSUE_WRFENCE=1, rsp 20 cycles after fence_valid ->
//     quiesce_done rises exactly 1+8+1+1+20 cycles after req; fence_valid is 1 cycle wide.
//  2. c1_not_empty held high 100 cycles after block ->
//     no fence_valid until the cycle after it drops; done follows the matching response.
//  3. c1_tx_almost_full high 5 cycles in FENCE -> fence_valid on cycle 6 only.
//  4. A response with mdata 'h3FE, then one with 'h3FF -> only the second completes.
//  5. req drops in DRAIN -> IDLE next cycle, afu_tx_block=0, no fence.
//     req drops in FENCE_WAIT -> block held until the response, then IDLE; done never set.
//  6. TIMEOUT_CYCLES=16, c0_not_empty stuck high ->
//     timeout=1 after 15 DRAIN cycles, state stays DRAIN; the next req cycle clears it.

Source files
------------

// File: rtl/cci_mpf_quiesce_ctrl.sv
// cci_mpf_quiesce_ctrl
//   Sequences an MPF instance into and out of a quiesced state for AFU context
//   switch. On request it blocks new AFU traffic, waits out the TX skid, waits
//   for both MPF channels to drain, optionally injects a WrFence on c1 and waits
//   for its response, then reports quiesced. Dropping the request resumes.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   quiesce_req         level request: 1 = quiesce, 0 = resume
//   quiesce_done        high only while QUIESCED
//   quiesce_timeout     sticky watchdog flag (report-only)
//   c0_not_empty        MPF reads outstanding
//   c1_not_empty        MPF writes outstanding
//   afu_tx_block        forces AFU almost-full / masks AFU TX valid
//   c1_tx_almost_full   FIU c1 almost-full, gates fence issue
//   fence_valid         one-cycle WrFence injection strobe
//   fence_mdata         constant FENCE_MDATA tag for the injected fence
//   fence_rsp_valid     c1 RX fence response valid
//   fence_rsp_mdata     mdata of that response
//   state_dbg           encoded FSM state for CSR readout
module cci_mpf_quiesce_ctrl #(
    parameter int          TX_SKEW_CYCLES = 8,
    parameter int          ISSUE_WRFENCE  = 1,
    parameter logic [15:0] FENCE_MDATA    = 16'h03FF,
    parameter int          TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        quiesce_req,
    output logic        quiesce_done,
    output logic        quiesce_timeout,
    input  logic        c0_not_empty,
    input  logic        c1_not_empty,
    output logic        afu_tx_block,
    input  logic        c1_tx_almost_full,
    output logic        fence_valid,
    output logic [15:0] fence_mdata,
    input  logic        fence_rsp_valid,
    input  logic [15:0] fence_rsp_mdata,
    output logic [2:0]  state_dbg
);

    localparam int SKW = $clog2(TX_SKEW_CYCLES) + 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SKW-1:0] SKEW_LAST = SKW'(TX_SKEW_CYCLES - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BLOCK      = 3'd1,
        DRAIN      = 3'd2,
        FENCE      = 3'd3,
        FENCE_WAIT = 3'd4,
        QUIESCED   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [SKW-1:0] skew_q, skew_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;
    logic           fence_valid_q, fence_valid_d;
    logic           block_q, block_d;
    logic           done_q, done_d;
    logic           rsp_match;

    assign rsp_match = fence_rsp_valid && (fence_rsp_mdata == FENCE_MDATA);

    always_comb begin
        state_d       = state_q;
        skew_d        = skew_q;
        wd_d          = wd_q;
        timeout_d     = timeout_q;
        fence_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (quiesce_req) begin
                    state_d   = BLOCK;
                    skew_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            BLOCK: begin
                if (!quiesce_req) begin
                    state_d = IDLE;
                end else if (skew_q == SKEW_LAST) begin
                    state_d = DRAIN;
                    wd_d    = '0;
                end else begin
                    skew_d = skew_q + 1'b1;
                end
            end
            DRAIN: begin
                // Abort takes priority over a drain that completes this cycle.
                if (!quiesce_req)
                    state_d = IDLE;
                else if (!c0_not_empty && !c1_not_empty)
                    state_d = (ISSUE_WRFENCE != 0) ? FENCE : QUIESCED;
            end
            FENCE: begin
                // Not abortable: once here the fence is always issued.
                if (!c1_tx_almost_full) begin
                    fence_valid_d = 1'b1;
                    state_d       = FENCE_WAIT;
                    wd_d          = '0;
                end
            end
            FENCE_WAIT: begin
                // A request drop is only honoured once our fence has returned.
                if (rsp_match)
                    state_d = quiesce_req ? QUIESCED : IDLE;
            end
            QUIESCED: begin
                if (!quiesce_req)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Saturating watchdog; the flag is informational, the FSM keeps waiting.
        if (state_q == DRAIN || state_q == FENCE_WAIT) begin
            if (wd_q != WD_LAST)
                wd_d = wd_q + 1'b1;
            if (wd_d == WD_LAST)
                timeout_d = 1'b1;
        end
    end

    assign block_d = (state_d != IDLE);
    assign done_d  = (state_d == QUIESCED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            skew_q        <= '0;
            wd_q          <= '0;
            timeout_q     <= 1'b0;
            fence_valid_q <= 1'b0;
            block_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            skew_q        <= skew_d;
            wd_q          <= wd_d;
            timeout_q     <= timeout_d;
            fence_valid_q <= fence_valid_d;
            block_q       <= block_d;
            done_q        <= done_d;
        end
    end

    assign quiesce_done    = done_q;
    assign quiesce_timeout = timeout_q;
    assign afu_tx_block    = block_q;
    assign fence_valid     = fence_valid_q;
    assign fence_mdata     = FENCE_MDATA;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_cci_mpf_quiesce_ctrl.sv
module tb_cci_mpf_quiesce_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        quiesce_req;
    logic        c0_not_empty, c1_not_empty, c1_tx_almost_full;
    logic        fence_rsp_valid;
    logic [15:0] fence_rsp_mdata;

    logic        done, timeout, block, fence_valid;
    logic [15:0] fence_mdata;
    logic [2:0]  state_dbg;

    logic        nf_done, nf_timeout, nf_block, nf_fence_valid;
    logic [15:0] nf_fence_mdata;
    logic [2:0]  nf_state_dbg;

    always #5 clk = ~clk;

    // Main instance: fence enabled, short watchdog.
    cci_mpf_quiesce_ctrl #(
        .TX_SKEW_CYCLES(8), .ISSUE_WRFENCE(1), .FENCE_MDATA(16'h03FF), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk(clk), .reset(reset), .quiesce_req(quiesce_req),
        .quiesce_done(done), .quiesce_timeout(timeout),
        .c0_not_empty(c0_not_empty), .c1_not_empty(c1_not_empty),
        .afu_tx_block(block), .c1_tx_almost_full(c1_tx_almost_full),
        .fence_valid(fence_valid), .fence_mdata(fence_mdata),
        .fence_rsp_valid(fence_rsp_valid), .fence_rsp_mdata(fence_rsp_mdata),
        .state_dbg(state_dbg)
    );

    // No-fence instance with a shorter skew, sharing the same inputs.
    cci_mpf_quiesce_ctrl #(
        .TX_SKEW_CYCLES(4), .ISSUE_WRFENCE(0), .FENCE_MDATA(16'h03FF), .TIMEOUT_CYCLES(65536)
    ) u_nf (
        .clk(clk), .reset(reset), .quiesce_req(quiesce_req),
        .quiesce_done(nf_done), .quiesce_timeout(nf_timeout),
        .c0_not_empty(c0_not_empty), .c1_not_empty(c1_not_empty),
        .afu_tx_block(nf_block), .c1_tx_almost_full(c1_tx_almost_full),
        .fence_valid(nf_fence_valid), .fence_mdata(nf_fence_mdata),
        .fence_rsp_valid(fence_rsp_valid), .fence_rsp_mdata(fence_rsp_mdata),
        .state_dbg(nf_state_dbg)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int c;
    int fence_q[$];
    int done_q[$];
    int nf_done_q[$];
    logic done_prev = 1'b0;
    logic nf_done_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample on the falling edge and match output events to the scoreboard.
    task automatic tick();
        int e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (fence_valid) begin
            e = (fence_q.size() > 0) ? fence_q.pop_front() : -1;
            chk("fence_cycle", cyc, e);
            chk("fence_mdata", {16'd0, fence_mdata}, 32'h3FF);
        end
        if (done && !done_prev) begin
            e = (done_q.size() > 0) ? done_q.pop_front() : -1;
            chk("done_cycle", cyc, e);
        end
        if (nf_done && !nf_done_prev) begin
            e = (nf_done_q.size() > 0) ? nf_done_q.pop_front() : -1;
            chk("nf_done_cycle", cyc, e);
        end
        if (nf_fence_valid)
            chk("nf_fence_never", 32'(nf_fence_valid), 32'd0);
        done_prev    = done;
        nf_done_prev = nf_done;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic send_rsp(input logic [15:0] md);
        fence_rsp_valid = 1'b1;
        fence_rsp_mdata = md;
        tick();
        fence_rsp_valid = 1'b0;
        fence_rsp_mdata = 16'h0;
    endtask

    initial begin
        reset = 1'b1; quiesce_req = 1'b0;
        c0_not_empty = 1'b0; c1_not_empty = 1'b0; c1_tx_almost_full = 1'b0;
        fence_rsp_valid = 1'b0; fence_rsp_mdata = 16'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_block", 32'(block), 32'd0);
        chk("rst_fence", 32'(fence_valid), 32'd0);
        chk("rst_mdata", 32'(fence_mdata), 32'h3FF);
        chk("rst_nf_state", 32'(nf_state_dbg), 32'd0);
        chk("rst_nf_block", 32'(nf_block), 32'd0);

        // 1: idle MPF, response 20 cycles after fence -> done at req+31 (nf: req+6)
        c = cyc;
        quiesce_req = 1'b1;
        fence_q.push_back(c + 11);
        done_q.push_back(c + 31);
        nf_done_q.push_back(c + 6);
        tick();
        chk("t1_block", 32'(block), 32'd1);
        chk("t1_state_block", 32'(state_dbg), 32'd1);
        wait_until(c + 30);
        send_rsp(16'h03FF);
        chk("t1_state_q", 32'(state_dbg), 32'd5);
        chk("t1_block_q", 32'(block), 32'd1);
        chk("t1_nf_state", 32'(nf_state_dbg), 32'd5);
        quiesce_req = 1'b0;
        tick();
        chk("t1_resume_state", 32'(state_dbg), 32'd0);
        chk("t1_resume_done", 32'(done), 32'd0);
        chk("t1_resume_block", 32'(block), 32'd0);
        chk("t1_nf_resume", 32'(nf_block), 32'd0);
        tick();

        // 2: c1_not_empty held 100 cycles after block
        c = cyc;
        quiesce_req = 1'b1;
        c1_not_empty = 1'b1;
        nf_done_q.push_back(c + 102);
        wait_until(c + 50);
        chk("t2_drain", 32'(state_dbg), 32'd2);
        chk("t2_nf_drain", 32'(nf_state_dbg), 32'd2);
        wait_until(c + 101);
        c1_not_empty = 1'b0;
        fence_q.push_back(c + 103);
        wait_until(c + 105);
        done_q.push_back(c + 106);
        send_rsp(16'h03FF);
        chk("t2_quiesced", 32'(state_dbg), 32'd5);
        quiesce_req = 1'b0;
        tick();
        tick();

        // 3+4: almost-full for 5 FENCE cycles; wrong-mdata response ignored
        c = cyc;
        c1_tx_almost_full = 1'b1;
        quiesce_req = 1'b1;
        nf_done_q.push_back(c + 6);
        wait_until(c + 12);
        chk("t3_fence_state", 32'(state_dbg), 32'd3);
        wait_until(c + 15);
        c1_tx_almost_full = 1'b0;
        fence_q.push_back(c + 16);
        wait_until(c + 18);
        send_rsp(16'h03FE);
        chk("t4_ignore_state", 32'(state_dbg), 32'd4);
        chk("t4_ignore_done", 32'(done), 32'd0);
        tick();
        done_q.push_back(c + 21);
        send_rsp(16'h03FF);
        chk("t4_quiesced", 32'(state_dbg), 32'd5);
        quiesce_req = 1'b0;
        tick();
        tick();

        // 5a: abort in DRAIN, coinciding with drain completion -> IDLE, no fence
        c = cyc;
        c1_not_empty = 1'b1;
        quiesce_req = 1'b1;
        wait_until(c + 12);
        chk("t5a_drain", 32'(state_dbg), 32'd2);
        quiesce_req = 1'b0;
        c1_not_empty = 1'b0;
        tick();
        chk("t5a_idle", 32'(state_dbg), 32'd0);
        chk("t5a_block", 32'(block), 32'd0);
        chk("t5a_nf_idle", 32'(nf_state_dbg), 32'd0);
        repeat (4) tick();

        // 5b: req drop in FENCE_WAIT -> block held until response, never done
        c = cyc;
        quiesce_req = 1'b1;
        fence_q.push_back(c + 11);
        nf_done_q.push_back(c + 6);
        wait_until(c + 14);
        quiesce_req = 1'b0;
        wait_until(c + 17);
        chk("t5b_wait_state", 32'(state_dbg), 32'd4);
        chk("t5b_wait_block", 32'(block), 32'd1);
        wait_until(c + 20);
        send_rsp(16'h03FF);
        chk("t5b_idle", 32'(state_dbg), 32'd0);
        chk("t5b_block", 32'(block), 32'd0);
        chk("t5b_done", 32'(done), 32'd0);
        tick();

        // 6: watchdog with c0 stuck; flag after 15 DRAIN cycles, cleared by next req
        c = cyc;
        c0_not_empty = 1'b1;
        quiesce_req = 1'b1;
        tick();
        chk("t6_clear_on_req", 32'(timeout), 32'd0);
        wait_until(c + 23);
        chk("t6_before", 32'(timeout), 32'd0);
        tick();
        chk("t6_set", 32'(timeout), 32'd1);
        chk("t6_state", 32'(state_dbg), 32'd2);
        wait_until(c + 40);
        chk("t6_hold", 32'(timeout), 32'd1);
        chk("t6_still_drain", 32'(state_dbg), 32'd2);
        quiesce_req = 1'b0;
        tick();
        chk("t6_abort_idle", 32'(state_dbg), 32'd0);
        chk("t6_sticky", 32'(timeout), 32'd1);
        quiesce_req = 1'b1;
        tick();
        chk("t6_cleared", 32'(timeout), 32'd0);
        quiesce_req = 1'b0;
        c0_not_empty = 1'b0;
        repeat (2) tick();

        // Reset mid-sequence, late fence response ignored in IDLE
        c = cyc;
        quiesce_req = 1'b1;
        fence_q.push_back(c + 11);
        nf_done_q.push_back(c + 6);
        wait_until(c + 12);
        chk("rm_wait", 32'(state_dbg), 32'd4);
        reset = 1'b1;
        quiesce_req = 1'b0;
        tick();
        chk("rm_state", 32'(state_dbg), 32'd0);
        chk("rm_block", 32'(block), 32'd0);
        chk("rm_nf_block", 32'(nf_block), 32'd0);
        reset = 1'b0;
        send_rsp(16'h03FF);
        chk("rm_rsp_state", 32'(state_dbg), 32'd0);
        chk("rm_rsp_done", 32'(done), 32'd0);
        tick();

        chk("sb_fence_left", 32'(fence_q.size()), 32'd0);
        chk("sb_done_left", 32'(done_q.size()), 32'd0);
        chk("sb_nf_done_left", 32'(nf_done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
